// File: rtl/uart_rx.sv
// ============================================================================
//  Module   : uart_rx
//  Purpose  : Oversampling UART receiver (start, WIDTH data LSB-first, stop)
//             with valid/ready holding register, framing-error and overrun.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rxIn,
    input  logic             ready,
    output logic [WIDTH-1:0] dataOut,
    output logic             valid,
    output logic             frameErr,
    output logic             overrun
);

    localparam int TW = $clog2(CLKS_PER_BIT) + 1;
    localparam int IW = $clog2(WIDTH) + 1;

    localparam logic [TW-1:0] C_T    = TW'(CLKS_PER_BIT);
    localparam logic [TW-1:0] H_T    = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] ONE_T  = TW'(1);
    localparam logic [IW-1:0] LAST_I = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        WAIT_HIGH = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q;
    logic               rxS_q;
    logic [TW-1:0]      timer_q, timer_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               ferr_q, ferr_d;
    logic               ovr_q, ovr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_HIGH;
            sync1_q <= 1'b1;
            rxS_q   <= 1'b1;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= rxIn;
            rxS_q   <= sync1_q;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // timer_q counts cycles since the last sample point (or since t0 in START);
    // a good-frame load below overrides the handshake clear of valid.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q & ~ready;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        case (state_q)
            WAIT_HIGH: begin
                if (rxS_q) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (!rxS_q) begin
                    timer_d = ONE_T;
                    idx_d   = '0;
                    // With H=0 the start bit is confirmed at t0 itself.
                    if (H_T == '0) begin
                        state_d = DATA;
                    end else begin
                        state_d = START;
                    end
                end
            end
            START: begin
                timer_d = timer_q + ONE_T;
                if (timer_q == H_T) begin
                    timer_d = ONE_T;
                    idx_d   = '0;
                    state_d = rxS_q ? IDLE : DATA;
                end
            end
            DATA: begin
                timer_d = timer_q + ONE_T;
                if (timer_q == C_T) begin
                    timer_d            = ONE_T;
                    shift_d            = shift_q >> 1;
                    shift_d[WIDTH-1]   = rxS_q;
                    if (idx_q == LAST_I) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            STOP: begin
                timer_d = timer_q + ONE_T;
                if (timer_q == C_T) begin
                    if (rxS_q) begin
                        state_d = IDLE;
                        if (valid_q && !ready) begin
                            ovr_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            default: begin
                state_d = WAIT_HIGH;
            end
        endcase
    end

    assign dataOut  = data_q;
    assign valid    = valid_q;
    assign frameErr = ferr_q;
    assign overrun  = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Directed self-checking bench for uart_rx (C=4 and C=1 instances).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx4, rx1;
    logic       ready4, ready1;
    logic [7:0] dout4, dout1;
    logic       valid4, valid1;
    logic       ferr4, ferr1;
    logic       ovr4, ovr1;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         ferr_hi  = 0;
    int         ovr_hi   = 0;
    int         n1       = 0;
    int         v1_cyc [4];
    logic [7:0] v1_dat [4];
    int         s;

    always #5 clk = ~clk;

    uart_rx #(.WIDTH(8), .CLKS_PER_BIT(4)) u4 (
        .clk(clk), .reset(reset), .rxIn(rx4), .ready(ready4),
        .dataOut(dout4), .valid(valid4), .frameErr(ferr4), .overrun(ovr4)
    );

    uart_rx #(.WIDTH(8), .CLKS_PER_BIT(1)) u1 (
        .clk(clk), .reset(reset), .rxIn(rx1), .ready(ready1),
        .dataOut(dout1), .valid(valid1), .frameErr(ferr1), .overrun(ovr1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse-width counters and C=1 delivery log, sampled mid-cycle.
    always @(negedge clk) begin
        if (ferr4) ferr_hi = ferr_hi + 1;
        if (ovr4)  ovr_hi  = ovr_hi + 1;
        if (valid1 && n1 < 4) begin
            v1_cyc[n1] = cyc;
            v1_dat[n1] = dout1;
            n1 = n1 + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive4(input logic b, input int n);
        rx4 = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive1(input logic b, input int n);
        rx1 = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send4(input logic [7:0] d, input logic stopb, input int stoplen);
        drive4(1'b0, 4);
        for (int i = 0; i < 8; i++) drive4(d[i], 4);
        drive4(stopb, stoplen);
    endtask

    task automatic send1(input logic [7:0] d);
        drive1(1'b0, 1);
        for (int i = 0; i < 8; i++) drive1(d[i], 1);
        drive1(1'b1, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        rx4    = 1'b1;
        rx1    = 1'b1;
        ready4 = 1'b0;
        ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data",  32'(dout4), 32'h0);
        check("rst_valid", 32'(valid4), 32'h0);
        check("rst_ferr",  32'(ferr4), 32'h0);
        check("rst_ovr",   32'(ovr4), 32'h0);
        reset = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end

        // Good frame: valid must appear exactly 41 edges after start drive.
        ready4 = 1'b1;
        send4(8'hA5, 1'b1, 4);
        check("good_valid_early", 32'(valid4), 32'h0);
        @(posedge clk); #1;
        check("good_valid", 32'(valid4), 32'h1);
        check("good_data",  32'(dout4), 32'hA5);
        @(posedge clk); #1;
        check("good_valid_clr", 32'(valid4), 32'h0);
        drive4(1'b1, 3);
        check("good_ferr", 32'(ferr_hi), 32'h0);

        // Glitch rejection
        drive4(1'b0, 1);
        drive4(1'b1, 20);
        check("glitch_valid", 32'(valid4), 32'h0);
        check("glitch_ferr",  32'(ferr_hi), 32'h0);
        check("glitch_ovr",   32'(ovr_hi), 32'h0);
        check("glitch_data",  32'(dout4), 32'hA5);

        // Framing error then recovery
        send4(8'h3C, 1'b0, 20);
        drive4(1'b1, 4);
        check("ferr_pulse", 32'(ferr_hi), 32'h1);
        check("ferr_valid", 32'(valid4), 32'h0);
        check("ferr_data",  32'(dout4), 32'hA5);
        send4(8'h81, 1'b1, 4);
        @(posedge clk); #1;
        check("rec_valid", 32'(valid4), 32'h1);
        check("rec_data",  32'(dout4), 32'h81);
        drive4(1'b1, 4);

        // Overrun
        ready4 = 1'b0;
        send4(8'h11, 1'b1, 4);
        send4(8'h22, 1'b1, 4);
        drive4(1'b1, 3);
        check("ovr_data",  32'(dout4), 32'h11);
        check("ovr_valid", 32'(valid4), 32'h1);
        check("ovr_pulse", 32'(ovr_hi), 32'h1);
        ready4 = 1'b1;
        @(posedge clk); #1;
        ready4 = 1'b0;
        check("ovr_drain", 32'(valid4), 32'h0);
        check("ovr_data_kept", 32'(dout4), 32'h11);

        // Reset during data bit 3 of 0xF0
        ready4 = 1'b1;
        drive4(1'b0, 4);
        drive4(1'b0, 12);
        drive4(1'b0, 2);
        reset = 1'b1;
        drive4(1'b0, 2);
        drive4(1'b1, 1);
        check("mid_rst_data",  32'(dout4), 32'h0);
        check("mid_rst_valid", 32'(valid4), 32'h0);
        drive4(1'b1, 2);
        reset = 1'b0;
        drive4(1'b1, 1);
        drive4(1'b1, 12);
        drive4(1'b1, 4);
        drive4(1'b1, 8);
        check("mid_rst_after_data",  32'(dout4), 32'h0);
        check("mid_rst_after_valid", 32'(valid4), 32'h0);
        check("mid_rst_after_ferr",  32'(ferr_hi), 32'h1);
        send4(8'h5A, 1'b1, 4);
        @(posedge clk); #1;
        check("post_rst_valid", 32'(valid4), 32'h1);
        check("post_rst_data",  32'(dout4), 32'h5A);
        drive4(1'b1, 4);

        // Minimum ratio C=1: two contiguous frames
        s = cyc;
        send1(8'h77);
        send1(8'h77);
        drive1(1'b1, 6);
        check("c1_count", 32'(n1), 32'd2);
        check("c1_first_cycle", 32'(v1_cyc[0] - s), 32'd12);
        check("c1_spacing", 32'(v1_cyc[1] - v1_cyc[0]), 32'd10);
        check("c1_data0", 32'(v1_dat[0]), 32'h77);
        check("c1_data1", 32'(v1_dat[1]), 32'h77);
        check("c1_ferr", 32'(ferr1), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

UART receiver that recovers framed serial words from an asynchronous line: 1 start bit (0), `WIDTH` data bits LSB first, 1 stop bit (1), idle high. It sits directly downstream of the team's UART transmitter, on the far end of the serial link. It oversamples by a fixed clock-cycles-per-bit ratio and presents each word through a valid/ready holding register, with framing-error and overrun indications.

## Interface
- `WIDTH`, default 8: data bits per frame, at least 1.
- `CLKS_PER_BIT`, default 16: `clk` cycles per bit, at least 1. A value of 1 matches a transmitter that shifts one bit per clock.
- `clk` in, 1 bit: clock; all logic is on its rising edge.
- `reset` in, 1 bit: synchronous, active-high.
- `rxIn` in, 1 bit: serial line, asynchronous to `clk`, idle high.
- `ready` in, 1 bit: consumer accepts `dataOut` in any cycle where `valid & ready`.
- `dataOut` out, `WIDTH` bits: last accepted-for-delivery word.
- `valid` out, 1 bit: `dataOut` holds an undelivered word.
- `frameErr` out, 1 bit: one-cycle pulse; the stop bit was sampled low.
- `overrun` out, 1 bit: one-cycle pulse; a good word was dropped because the holding register was full.

## Operation
- **Input synchronizer:** `rxIn` passes through 2 flops; the output is `rxS`. Both flops reset to 1. All decisions use `rxS`.
- **Constants:** C = `CLKS_PER_BIT`, H = floor(C/2).
- **FSM states:** WAIT_HIGH, IDLE, START, DATA, STOP. Reset state is WAIT_HIGH.
- **WAIT_HIGH:** go to IDLE on the first cycle with `rxS`=1.
- **IDLE:** when `rxS`=0, call that cycle t0, clear the bit-timer, and go to START. If H=0, START samples at t0 itself.
- **START:** sample at t0+H.
  - `rxS`=0: go to DATA with the bit index cleared.
  - `rxS`=1: false start; return to IDLE. No flags.
- **DATA:** data bit i (i = 0..WIDTH-1) is sampled at t0+H+(i+1)·C and shifted in LSB first. After bit WIDTH-1, go to STOP.
- **STOP:** sample at t0+H+(WIDTH+1)·C.
  - `rxS`=1: the frame is good; go to IDLE on the next cycle. A new start bit may be detected from the cycle after the stop sample.
  - `rxS`=0: pulse `frameErr`, discard the word, and go to WAIT_HIGH.
- **Holding register:** a good frame loads `dataOut` and sets `valid` unless `valid` is 1 and `ready` is 0. In that case:
  - pulse `overrun`;
  - drop the new word;
  - leave `dataOut` unchanged.
- **Handshake:** `valid & ready` clears `valid` on the next edge.
  - If a good frame completes in the same cycle as the handshake, the new word loads, `valid` stays 1, and there is no overrun.
  - `dataOut` is stable while `valid`=1.
- **Reset:** asserting reset at any time, including mid-frame, has these effects:
  - outputs go to `dataOut`=0, `valid`=0, `frameErr`=0, `overrun`=0;
  - synchronizer flops go to 1;
  - FSM goes to WAIT_HIGH;
  - the partial frame is discarded.
  
  The WAIT_HIGH entry prevents mis-framing mid-frame after reset.
- **Counters:** bit-timer is $clog2(C)+1 bits; bit index is $clog2(WIDTH)+1 bits. Neither wraps within a frame.

## Timing
- `rxIn` to `rxS`: 2 cycles.
- `valid` rises (and `frameErr`/`overrun` pulse) on the edge after the stop sample, i.e. cycle t0+H+(WIDTH+1)·C+1. That is 3+H+(WIDTH+1)·C cycles after `rxIn` is first registered low.
- `frameErr` and `overrun` are high for exactly 1 cycle each.
- **Throughput:**
  - Back-to-back frames with a full stop bit are received without loss.
  - Frames spaced by as little as (WIDTH+2)·C cycles are supported, provided the consumer drains one word per frame time.
- **Simultaneous events:** reset has priority over everything. A good-frame load has priority over handshake clearing.

## Test plan
- **Good frame:** WIDTH=8, C=4, send framed 0xA5 with `ready`=1 → `dataOut`=0xA5 and `valid` high for 1 cycle at t0+2+9·4+1; `frameErr`=0.
- **Glitch rejection:** C=4, `rxIn` low for 1 cycle then high → FSM returns to IDLE; `valid`, `frameErr` and `overrun` stay 0.
- **Framing error:** C=4, send 0x3C with stop bit 0 held low for 20 cycles → one `frameErr` pulse and `valid` stays 0. The next frame 0x81, sent after the line returns high, is received as 0x81.
- **Overrun:** with `ready`=0, send 0x11 then 0x22 back-to-back → `dataOut`=0x11, `valid`=1, one `overrun` pulse at the end of the second frame, `dataOut` still 0x11. Then `ready`=1 for 1 cycle → `valid`=0.
- **Reset mid-frame:** assert reset during data bit 3 of 0xF0 → outputs become 0 and the rest of that frame produces nothing. A following frame 0x5A gives `dataOut`=0x5A.
- **Minimum ratio:** C=1, WIDTH=8, two contiguous frames 0x77 and 0x77 with `ready`=1 → two `valid` pulses, 10 cycles apart, each with `dataOut`=0x77.
